// File: rtl/aes_word_loader.sv
// Stream adapter for an AES-128 core: packs 32-bit input words into key/plaintext,
// starts the core, waits (with timeout) for the result and streams the ciphertext out.
module aes_word_loader #(
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_load_key,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [31:0]  m_data,
    output logic         m_last,
    output logic         core_start,
    output logic [127:0] core_key,
    output logic [127:0] core_plaintext,
    input  logic [127:0] core_ciphertext,
    input  logic         core_done,
    input  logic         err_clear,
    output logic         busy,
    output logic         err_nokey,
    output logic         err_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_KEY,
        ST_LOAD_PT,
        ST_START,
        ST_WAIT,
        ST_UNLOAD
    } state_t;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t         state, state_nxt;
    logic [127:0]   key_q, pt_q, ct_q;
    logic           key_valid;
    logic [1:0]     cnt;
    logic [TW-1:0]  timer;
    logic           s_fire, m_fire, nokey_evt, timeout_evt;

    // Word 0 is the most significant 32 bits of every 128-bit quantity.
    function automatic logic [127:0] put_word(input logic [127:0] v, input logic [1:0] idx,
                                              input logic [31:0] w);
        logic [127:0] r;
        r = v;
        case (idx)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] get_word(input logic [127:0] v, input logic [1:0] idx);
        logic [31:0] r;
        case (idx)
            2'd0:    r = v[127:96];
            2'd1:    r = v[95:64];
            2'd2:    r = v[63:32];
            default: r = v[31:0];
        endcase
        return r;
    endfunction

    assign s_ready        = (state == ST_IDLE) || (state == ST_LOAD_KEY) || (state == ST_LOAD_PT);
    assign m_valid        = (state == ST_UNLOAD);
    assign m_data         = m_valid ? get_word(ct_q, cnt) : 32'h0;
    assign m_last         = m_valid && (cnt == 2'd3);
    assign core_start     = (state == ST_START);
    assign busy           = (state != ST_IDLE);
    assign core_key       = key_q;
    assign core_plaintext = pt_q;

    assign s_fire      = s_valid && s_ready;
    assign m_fire      = m_valid && m_ready;
    assign nokey_evt   = (state == ST_IDLE) && s_fire && !s_load_key && !key_valid;
    // A done in the final WAIT cycle takes priority over the timeout.
    assign timeout_evt = (state == ST_WAIT) && !core_done && (timer == TIMER_LAST);

    always_comb begin
        // NOTE: holding state by default means every path assigns state_nxt, so no latch is inferred.
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (s_fire && s_load_key)     state_nxt = ST_LOAD_KEY;
                else if (s_fire && key_valid) state_nxt = ST_LOAD_PT;
            end
            ST_LOAD_KEY: if (s_fire && cnt == 2'd3) state_nxt = ST_LOAD_PT;
            ST_LOAD_PT:  if (s_fire && cnt == 2'd3) state_nxt = ST_START;
            ST_START:    state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (core_done)        state_nxt = ST_UNLOAD;
                else if (timeout_evt) state_nxt = ST_IDLE;
            end
            ST_UNLOAD:   if (m_fire && cnt == 2'd3) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            key_q       <= '0;
            pt_q        <= '0;
            ct_q        <= '0;
            key_valid   <= 1'b0;
            cnt         <= 2'd0;
            timer       <= '0;
            err_nokey   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (s_fire && s_load_key) begin
                        key_q <= put_word(key_q, 2'd0, s_data);
                        cnt   <= 2'd1;
                    end else if (s_fire && key_valid) begin
                        pt_q  <= put_word(pt_q, 2'd0, s_data);
                        cnt   <= 2'd1;
                    end
                end
                ST_LOAD_KEY: begin
                    if (s_fire) begin
                        key_q <= put_word(key_q, cnt, s_data);
                        cnt   <= cnt + 2'd1;
                        if (cnt == 2'd3) key_valid <= 1'b1;
                    end
                end
                ST_LOAD_PT: begin
                    if (s_fire) begin
                        pt_q <= put_word(pt_q, cnt, s_data);
                        cnt  <= cnt + 2'd1;
                    end
                end
                ST_START: timer <= '0;
                ST_WAIT: begin
                    if (core_done) begin
                        ct_q <= core_ciphertext;
                        cnt  <= 2'd0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_UNLOAD: if (m_fire) cnt <= cnt + 2'd1;
                default: ;
            endcase

            if (nokey_evt)      err_nokey <= 1'b1;
            else if (err_clear) err_nokey <= 1'b0;

            if (timeout_evt)    err_timeout <= 1'b1;
            else if (err_clear) err_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_word_loader.sv
// Self-checking bench for aes_word_loader: behavioural AES-128 core, output scoreboard,
// back-pressure driver and directed error/timeout/reset scenarios.
module tb_aes_word_loader;

    localparam int TIMEOUT = 64;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef enum logic [1:0] {CORE_NORMAL, CORE_NEVER, CORE_AT_LIMIT} core_mode_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         s_valid, s_ready, s_load_key;
    logic [31:0]  s_data;
    logic         m_valid, m_ready, m_last;
    logic [31:0]  m_data;
    logic         core_start, core_done;
    logic [127:0] core_key, core_plaintext, core_ciphertext;
    logic         err_clear, busy, err_nokey, err_timeout;

    core_mode_t   core_mode;
    logic         bp_en, gaps;
    int           stall_cnt;
    int           start_cnt;
    int           n_checks, n_pass, n_fail;
    logic [32:0]  exp_q[$];

    aes_word_loader #(.TIMEOUT(TIMEOUT), .TW(7)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_load_key(s_load_key),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .core_start(core_start), .core_key(core_key), .core_plaintext(core_plaintext),
        .core_ciphertext(core_ciphertext), .core_done(core_done),
        .err_clear(err_clear), .busy(busy), .err_nokey(err_nokey), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // ---------------- AES-128 reference used as the attached core ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = x;
        for (int i = 0; i < 253; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   st [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])}
                      ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox(st[i]);
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) st[4*c+row] = t[4*((c+row)%4)+row];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) st[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    // ---------------- core model ----------------
    initial begin
        logic [127:0] k, p, c;
        core_done       = 1'b0;
        core_ciphertext = '0;
        forever begin
            @(negedge clk);
            if (core_start && core_mode != CORE_NEVER) begin
                k = core_key;
                p = core_plaintext;
                c = aes128(k, p);
                repeat ((core_mode == CORE_NORMAL) ? 5 : TIMEOUT) @(posedge clk);
                #1;
                check("core_key_stable", core_key, k);
                check("core_pt_stable", core_plaintext, p);
                core_done       = 1'b1;
                core_ciphertext = c;
                @(posedge clk);
                #1;
                core_done       = 1'b0;
            end
        end
    end

    // ---------------- downstream ready driver ----------------
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = !bp_en || (stall_cnt >= 3);
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    initial begin
        logic        prev_stall, prev_start, prev_last, waiting;
        logic [31:0] prev_data;
        logic [32:0] e;
        prev_stall = 1'b0; prev_start = 1'b0; prev_last = 1'b0; waiting = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0; prev_start = 1'b0; waiting = 1'b0; stall_cnt = 0;
            end else begin
                if (core_start) begin
                    check("start_one_cycle", prev_start, 1'b0);
                    start_cnt++;
                    waiting = 1'b1;
                end else if (m_valid || !busy) begin
                    waiting = 1'b0;
                end
                if (waiting || m_valid) check("s_ready_low", s_ready, 1'b0);
                if (m_valid && prev_stall) begin
                    check("stall_m_data", m_data, prev_data);
                    check("stall_m_last", m_last, prev_last);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", m_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", m_data, e[31:0]);
                        check("m_last", m_last, e[32]);
                    end
                    stall_cnt = 0;
                end else if (m_valid) begin
                    stall_cnt++;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
                prev_start = core_start;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic lk);
        logic rdy;
        int   n;
        rdy = 1'b0;
        n   = 0;
        s_valid = 1'b1; s_data = d; s_load_key = lk;
        while (!rdy && n < 300) begin
            @(negedge clk);
            rdy = s_ready;
            tick();
            n++;
        end
        if (!rdy) check("s_ready_timeout", rdy, 1'b1);
        s_valid = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic send_block(input logic [127:0] key, input logic [127:0] pt, input logic lk,
                              input logic expect_out, input logic [127:0] ct);
        logic [127:0] v;
        if (expect_out)
            for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), ct[127-32*i -: 32]});
        if (lk) begin
            v = key;
            for (int i = 0; i < 4; i++) send_word(v[127-32*i -: 32], (i == 0) ? 1'b1 : 1'b0);
        end
        v = pt;
        for (int i = 0; i < 4; i++) send_word(v[127-32*i -: 32], (i == 0) ? lk : ~lk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check(tag, busy, 1'b0);
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!core_start && n < 20);
        if (!core_start) check("start_missing", core_start, 1'b1);
    endtask

    task automatic pulse_err_clear();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        tick();
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_busy"}, busy, 1'b0);
        check({p, "_s_ready"}, s_ready, 1'b1);
        check({p, "_m_valid"}, m_valid, 1'b0);
        check({p, "_m_last"}, m_last, 1'b0);
        check({p, "_m_data"}, m_data, 32'h0);
        check({p, "_core_start"}, core_start, 1'b0);
        check({p, "_core_key"}, core_key, 128'h0);
        check({p, "_core_pt"}, core_plaintext, 128'h0);
        check({p, "_err_nokey"}, err_nokey, 1'b0);
        check({p, "_err_timeout"}, err_timeout, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] k2, pt, ct;
        int           starts_before, wcyc;
        n_checks = 0; n_pass = 0; n_fail = 0;
        start_cnt = 0; stall_cnt = 0;
        reset_n = 1'b0; s_valid = 1'b0; s_data = '0; s_load_key = 1'b0; err_clear = 1'b0;
        core_mode = CORE_NORMAL; bp_en = 1'b0; gaps = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Plaintext-only block with no key ever loaded.
        send_word(32'hdeadbeef, 1'b0);
        tick();
        check("nokey_err", err_nokey, 1'b1);
        check("nokey_idle", busy, 1'b0);
        check("nokey_no_start", start_cnt, 0);
        pulse_err_clear();
        check("nokey_cleared", err_nokey, 1'b0);

        // FIPS-197 vector, full load, then key reuse.
        send_block(FIPS_KEY, FIPS_PT, 1'b1, 1'b1, FIPS_CT);
        wait_idle("fips_drain");
        check("fips_starts", start_cnt, 1);
        send_block(FIPS_KEY, FIPS_PT, 1'b0, 1'b1, FIPS_CT);
        wait_idle("reuse_drain");
        check("reuse_starts", start_cnt, 2);
        check("reuse_core_key", core_key, FIPS_KEY);

        // Back-pressure with random input gaps.
        bp_en = 1'b1;
        gaps  = 1'b1;
        k2 = {$urandom, $urandom, $urandom, $urandom};
        for (int b = 0; b < 3; b++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            send_block(k2, pt, (b == 0), 1'b1, aes128(k2, pt));
        end
        wait_idle("bp_drain");
        check("bp_starts", start_cnt, 5);
        bp_en = 1'b0;
        gaps  = 1'b0;
        tick();

        // Core never answers: timeout after TIMEOUT WAIT cycles.
        core_mode = CORE_NEVER;
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block(k2, pt, 1'b0, 1'b0, '0);
        wait_start();
        wcyc = 0;
        while (wcyc < 200) begin
            @(negedge clk);
            if (err_timeout) break;
            wcyc++;
        end
        check("timeout_wait_cycles", wcyc, TIMEOUT);
        check("timeout_busy", busy, 1'b0);
        check("timeout_m_valid", m_valid, 1'b0);
        tick();
        pulse_err_clear();
        check("timeout_cleared", err_timeout, 1'b0);

        // Done in the same cycle as the timeout: done wins; key kept after the timeout.
        core_mode = CORE_AT_LIMIT;
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block(k2, pt, 1'b0, 1'b1, aes128(k2, pt));
        wait_idle("limit_drain");
        check("limit_no_timeout", err_timeout, 1'b0);
        check("limit_starts", start_cnt, 7);

        // Reset in the middle of WAIT.
        core_mode = CORE_NEVER;
        send_block(k2, pt, 1'b0, 1'b0, '0);
        wait_start();
        repeat (10) tick();
        check("midwait_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midwait_reset");
        tick();
        reset_n = 1'b1;
        tick();
        starts_before = start_cnt;
        send_word(32'hdeadbeef, 1'b0);
        tick();
        check("post_reset_nokey", err_nokey, 1'b1);
        check("post_reset_idle", busy, 1'b0);
        check("post_reset_no_start", start_cnt, starts_before);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_word_loader.md
Name: aes_word_loader

Overview:
- Upstream/downstream stream adapter for the AES-128 encryption core.
- Collects 32-bit words from an input stream into a 128-bit key and plaintext, then issues a one-cycle start to the core.
- Waits for core done with a timeout, captures the ciphertext, and streams it back out as four 32-bit words.
- Holds the last key so subsequent blocks can reuse it without reloading.

Parameters:
- TIMEOUT, 64: max cycles in WAIT for core_done before aborting; must be >= 2.
- TW, 7: timer width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid & s_ready.
- s_data  in  32  input word.
- s_load_key  in  1  sampled with first word of a block only: 1 = 8-word block (key then plaintext), 0 = 4-word plaintext-only block.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts word.
- m_data  out  32  ciphertext word.
- m_last  out  1  high with 4th ciphertext word.
- core_start  out  1  one-cycle start pulse to core.
- core_key  out  128  key to core.
- core_plaintext  out  128  plaintext to core.
- core_ciphertext  in  128  core result.
- core_done  in  1  core result valid.
- err_clear  in  1  clears sticky errors.
- busy  out  1  state != IDLE.
- err_nokey  out  1  sticky: plaintext-only block arrived with no key ever loaded.
- err_timeout  out  1  sticky: core_done not seen within TIMEOUT cycles.

Behaviour:
- Reset (async, any state): state IDLE; key/plaintext/ciphertext registers 0; key_valid 0; word count 0; timer 0; core_start 0; m_valid 0; m_last 0; m_data 0; errors 0; busy 0; s_ready 1 (decoded from IDLE).
- Word order is most-significant word first: word 0 goes to bits [127:96], word 3 to bits [31:0], for key, plaintext and ciphertext alike.
- s_ready = 1 in IDLE, LOAD_KEY and LOAD_PT; 0 elsewhere.
- m_valid = 1 only in UNLOAD.
- FSM:
  - IDLE, on a transfer:
    - s_load_key=1: word to key[127:96]; cnt=1; go to LOAD_KEY.
    - s_load_key=0 and key_valid=1: word to pt[127:96]; cnt=1; go to LOAD_PT.
    - s_load_key=0 and key_valid=0: word discarded; err_nokey set; stay IDLE.
  - LOAD_KEY: accept words 1..3 into key. After word 3: key_valid set; cnt=0; go to LOAD_PT.
  - LOAD_PT: accept remaining plaintext words. After word 3, go to START. s_load_key is ignored outside IDLE.
  - START: core_start=1 for exactly this cycle; timer cleared; go to WAIT.
  - WAIT:
    - core_done=1: capture core_ciphertext; cnt=0; go to UNLOAD.
    - Else timer increments. At timer == TIMEOUT-1 with no done: err_timeout set; go to IDLE; no output produced; key_valid kept.
    - core_done and timeout in the same cycle: done wins.
  - UNLOAD: m_data = captured word cnt; m_last = (cnt==3). On m_ready, cnt increments. After word 3 is accepted, go to IDLE.
- m_data and m_last are stable while m_valid & !m_ready.
- core_key and core_plaintext are driven straight from their registers. They change only on LOAD-state transfers, so both are stable from START through WAIT.
- A core_done seen outside WAIT is ignored.
- err_clear clears both sticky errors in the next cycle. If an error sets in the same cycle as err_clear, set wins.
- Reset mid-operation: block abandoned. key_valid cleared, so the next block must load a key.
- Back-to-back: IDLE accepts the next first word in the cycle after the final UNLOAD handshake.

Test Plan:
- FIPS-197 vector, full load:
  - Stimulus: s_load_key=1; words 00010203, 04050607, 08090a0b, 0c0d0e0f, 00112233, 44556677, 8899aabb, ccddeeff; real core attached.
  - Response: one core_start pulse; output words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; m_last only on the 4th word.
- Key reuse:
  - Stimulus: repeat the plaintext with s_load_key=0 after the first block.
  - Response: identical ciphertext; core_key still 000102030405060708090a0b0c0d0e0f.
- Back-pressure:
  - Stimulus: random s_valid gaps and m_ready low 3 cycles per word.
  - Response: no lost or duplicated words; m_data constant while stalled; s_ready 0 during START/WAIT/UNLOAD.
- No-key error:
  - Stimulus: after reset, send word deadbeef with s_load_key=0.
  - Response: err_nokey=1; state IDLE; no core_start. err_clear pulse returns err_nokey to 0.
- Timeout:
  - Stimulus: stub core never asserts done.
  - Response: err_timeout=1 exactly 64 cycles after START; busy=0; m_valid never asserted. A done arriving in the same cycle as the timeout instead yields UNLOAD with no error.
- Reset mid-WAIT:
  - Stimulus: assert reset_n=0 during WAIT.
  - Response: all outputs immediately at reset values; key_valid 0; a following s_load_key=0 block raises err_nokey.
